countdown_timer: RTL

Programmable down-counting timer for the single-cycle MIPS CPU system on the Nexys 4 DDR. It is the decrementing counterpart of the free-running up counter:
- Software loads a reload value and starts the timer.
- The timer counts down to zero on qualified ticks.
- On reaching zero it pulses `expired` and raises a sticky `irq` until acknowledged.
- It supports one-shot and auto-reload modes.

---
 rtl/timer_pkg.sv | 15 +
 rtl/countdown_timer_if.sv | 33 +++
 rtl/tick_prescaler.sv | 33 +++
 rtl/countdown_timer.sv | 112 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and width defaults for the countdown timer.
// FSM state encoding lives here so the top and the bench agree on it.
package timer_pkg;

    localparam int STATE_W            = 2;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_PRESCALE_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between software-side logic and the timer.
// master drives controls, slave is the timer itself.
interface countdown_timer_if #(
    parameter int DATA_WIDTH     = timer_pkg::DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = timer_pkg::DEF_PRESCALE_WIDTH
);

    logic                      enable;
    logic                      load;
    logic [DATA_WIDTH-1:0]     load_value;
    logic                      start;
    logic                      stop;
    logic                      auto_reload;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      irq_ack;
    logic [DATA_WIDTH-1:0]     count_out;
    logic                      running;
    logic                      expired;
    logic                      irq;

    modport master (
        output enable, load, load_value, start, stop,
        output auto_reload, prescale, irq_ack,
        input  count_out, running, expired, irq
    );

    modport slave (
        input  enable, load, load_value, start, stop,
        input  auto_reload, prescale, irq_ack,
        output count_out, running, expired, irq
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by prescale+1; used only with
// COUNTDOWN_TIMER_PRESCALER_EN defined.
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

    // >= keeps the divider sane if prescale shrinks mid-count
    assign tick = enable & ~clear & (cnt_q >= prescale);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot/auto-reload and sticky irq.
// Optional tick prescaler: define COUNTDOWN_TIMER_PRESCALER_EN.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    countdown_timer_if.slave tif
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  expired_q, expired_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] eff_count;
    logic                  tick;

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    logic pre_clear;
    assign pre_clear = tif.stop | ((state_q == IDLE) & tif.start);

    tick_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (tif.enable),
        .clear    (pre_clear),
        .prescale (tif.prescale),
        .tick     (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^tif.prescale;
    assign tick            = tif.enable;
`endif

    assign eff_count = tif.load ? tif.load_value : count_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        irq_d     = irq_q & ~tif.irq_ack;
        unique case (state_q)
            IDLE: begin
                if (tif.load) begin
                    reload_d = tif.load_value;
                    count_d  = tif.load_value;
                end
                if (tif.start && !tif.stop && eff_count != '0)
                    state_d = RUN;
            end
            RUN: begin
                if (tif.load) reload_d = tif.load_value;
                if (tif.stop) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    if (count_q == DATA_WIDTH'(1)) begin
                        expired_d = 1'b1;
                        irq_d     = 1'b1;
                        if (tif.auto_reload && reload_q != '0) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else if (count_q != '0) begin
                        count_d = count_q - DATA_WIDTH'(1);
                    end
                end
            end
            PAUSED: begin
                if (tif.load) reload_d = tif.load_value;
                if (tif.stop) begin
                    state_d = IDLE;
                    count_d = reload_q;
                end else if (tif.start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
            irq_q     <= irq_d;
        end
    end

    assign tif.count_out = count_q;
    assign tif.running   = (state_q == RUN);
    assign tif.expired   = expired_q;
    assign tif.irq       = irq_q;

endmodule
